// File: rtl/apb_fifo_slave.sv
// APB responder with a 4-word register window: scratch, status, and push/pop
// ports into a DEPTH-entry 32-bit FIFO mailbox, with fixed access wait states.
module apb_fifo_slave #(
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY
);

  // state   | meaning
  // ST_IDLE | no transfer in flight, waiting for a setup phase
  // ST_WAIT | transfer accepted, counting access-phase wait states
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam int AW = $clog2(DEPTH);

  state_t          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [31:0]     scratch_q;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q;
  logic            ovf_q, unf_q;
  logic [31:0]     mem [DEPTH];

  logic [1:0]      sel;
  logic            full, empty;
  logic            wr_cmt, rd_cmt;
  logic            push, pop, ovf_set, unf_set, sts_wr;
  logic [31:0]     status;

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    PREADY  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_WAIT;
          wcnt_d  = '0;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          if (wcnt_q == 4'(WAIT_CYCLES)) begin
            PREADY  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PREADY already implies PSEL & PENABLE, so it marks the completion edge.
  assign sel     = PADDR[3:2];
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign wr_cmt  = PREADY && PWRITE;
  assign rd_cmt  = PREADY && !PWRITE;
  assign push    = wr_cmt && (sel == 2'd2) && !full;
  assign ovf_set = wr_cmt && (sel == 2'd2) && full;
  assign pop     = rd_cmt && (sel == 2'd3) && !empty;
  assign unf_set = rd_cmt && (sel == 2'd3) && empty;
  assign sts_wr  = wr_cmt && (sel == 2'd1);
  assign status  = 32'({cnt_q, unf_q, ovf_q, full, empty});

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      scratch_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (wr_cmt && (sel == 2'd0)) scratch_q <= PWDATA;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        cnt_q  <= cnt_q - 1'b1;
      end
      // Clear is evaluated last so a W1C beats a same-cycle set.
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
      if (sts_wr && PWDATA[2]) ovf_q <= 1'b0;
      if (sts_wr && PWDATA[3]) unf_q <= 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[wptr_q] <= PWDATA;
  end

  always_comb begin
    PRDATA = '0;
    if (rd_cmt) begin
      case (sel)
        2'd0:    PRDATA = scratch_q;
        2'd1:    PRDATA = status;
        2'd3:    PRDATA = empty ? 32'd0 : mem[rptr_q];
        default: PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Bench for apb_fifo_slave: directed register/FIFO scenarios followed by
// random APB traffic checked against a queue-based mailbox model.
module tb_apb_fifo_slave;
  localparam int DEPTH = 8;
  localparam int WC    = 1;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;

  apb_fifo_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad = 0;

  logic [31:0] m_q[$];
  logic [31:0] m_scr = '0;
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  function automatic logic [31:0] m_status();
    bit f, e;
    f = (m_q.size() == DEPTH);
    e = (m_q.size() == 0);
    return (32'(m_q.size()) << 4) | {28'd0, m_unf, m_ovf, f, e};
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_scr = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rdata);
    int  waits;
    bit  done;
    waits = 0;
    done  = 1'b0;
    rdata = '0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    while (!done && waits <= 20) begin
      @(negedge PCLK);
      if (PREADY) begin
        done  = 1'b1;
        rdata = PRDATA;
      end else begin
        chk("prdata_not_ready", PRDATA, 32'd0);
        waits++;
        @(posedge PCLK); #1;
      end
    end
    chk("wait_states", 32'(waits), 32'(WC));
    if (done) begin
      @(posedge PCLK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic op(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                    output logic [31:0] rd);
    logic [31:0] exp;
    logic [1:0]  sel;
    sel = addr[3:2];
    exp = '0;
    if (!wr) begin
      case (sel)
        2'd0: exp = m_scr;
        2'd1: exp = m_status();
        2'd3: exp = (m_q.size() > 0) ? m_q[0] : 32'd0;
        default: exp = '0;
      endcase
    end
    xfer(wr, addr, data, rd);
    if (wr) begin
      case (sel)
        2'd0: m_scr = data;
        2'd1: begin
          if (data[2]) m_ovf = 1'b0;
          if (data[3]) m_unf = 1'b0;
        end
        2'd2: begin
          if (m_q.size() == DEPTH) m_ovf = 1'b1;
          else m_q.push_back(data);
        end
        default: ;
      endcase
    end else begin
      if (sel == 2'd3) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_unf = 1'b1;
      end
      chk($sformatf("read_sel%0d", sel), rd, exp);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] tmp;
    logic [31:0] addr;
    int          r;

    // reset held for two edges
    PRESET = 1'b0;
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("reset_pready", 32'(PREADY), 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    op(1'b0, 32'h4, 32'h0, rd);
    chk("reset_status", rd, 32'h0000_0001);

    op(1'b1, 32'h0, 32'hDEAD_BEEF, rd);
    op(1'b0, 32'h0, 32'h0, rd);
    chk("scratch", rd, 32'hDEAD_BEEF);

    for (int i = 1; i <= 9; i++) begin
      op(1'b1, 32'h8, 32'(i), rd);
      if (i == 8) begin
        op(1'b0, 32'h4, 32'h0, rd);
        chk("status_full", rd, 32'h0000_0082);
      end
    end
    op(1'b0, 32'h4, 32'h0, rd);
    chk("status_overflow", rd, 32'h0000_0086);
    op(1'b1, 32'h4, 32'h4, rd);
    op(1'b0, 32'h4, 32'h0, rd);
    chk("status_ovf_clear", rd, 32'h0000_0082);

    for (int i = 1; i <= 9; i++) begin
      op(1'b0, 32'hC, 32'h0, rd);
      chk($sformatf("drain_%0d", i), rd, (i <= 8) ? 32'(i) : 32'd0);
    end
    op(1'b0, 32'h4, 32'h0, rd);
    chk("status_underflow", rd, 32'h0000_0009);
    op(1'b1, 32'h4, 32'h8, rd);

    for (int i = 0; i < 5; i++) op(1'b1, 32'h8, 32'h100 + 32'(i), rd);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 32'hC, 32'h0, rd);
      chk("wrap_a", rd, 32'h100 + 32'(i));
    end
    for (int i = 0; i < 6; i++) op(1'b1, 32'h8, 32'h200 + 32'(i), rd);
    for (int i = 0; i < 6; i++) begin
      op(1'b0, 32'hC, 32'h0, rd);
      chk("wrap_b", rd, 32'h200 + 32'(i));
    end
    op(1'b0, 32'h4, 32'h0, rd);
    chk("wrap_status", rd, 32'h0000_0001);

    // abort: PSEL drops while the push is still waiting
    op(1'b1, 32'h8, 32'h55, rd);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h8; PWDATA = 32'h1234;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort_pready", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    op(1'b0, 32'h4, 32'h0, rd);
    chk("abort_status", rd, 32'h0000_0010);

    // reset during the wait phase of a pop
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'hC;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("rst_mid_pready", 32'(PREADY), 32'd0);
    chk("rst_mid_prdata", PRDATA, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    m_reset();
    op(1'b0, 32'h4, 32'h0, rd);
    chk("rst_mid_status", rd, 32'h0000_0001);
    op(1'b0, 32'h0, 32'h0, rd);
    chk("rst_mid_scratch", rd, 32'h0);

    // random traffic against the model; upper/lower address bits are noise
    for (int n = 0; n < 150; n++) begin
      r   = int'($urandom_range(0, 9));
      tmp = $urandom();
      if (r <= 3) begin
        addr = {tmp[31:4], 2'd2, tmp[1:0]};
        op(1'b1, addr, $urandom(), rd);
      end else if (r <= 6) begin
        addr = {tmp[31:4], 2'd3, tmp[1:0]};
        op(r == 6 && tmp[4], addr, $urandom(), rd);
      end else if (r == 7) begin
        addr = {tmp[31:4], 2'd1, tmp[1:0]};
        op(1'b0, addr, 32'h0, rd);
      end else if (r == 8) begin
        addr = {tmp[31:4], 2'd1, tmp[1:0]};
        op(1'b1, addr, $urandom(), rd);
      end else begin
        addr = {tmp[31:4], 2'd0, tmp[1:0]};
        op(tmp[5], addr, $urandom(), rd);
      end
    end
    op(1'b0, 32'h4, 32'h0, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_fifo_slave.md
# apb_fifo_slave

APB responder peripheral that answers the transfers issued by the bus master's SETUP/ACCESS sequence. It decodes a 4-word register window: a scratch register, a status register, a push port and a pop port into an internal DEPTH-entry 32-bit FIFO mailbox. A programmable number of wait states is inserted on every transfer through PREADY. It sits behind one PSELx/PRDATAx/PREADYx slot of the master.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..256
- WAIT_CYCLES, 1: PREADY-low cycles in the access phase before completion; 0..15
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous, active-low reset
- PSEL  in  1  select from master decoder
- PENABLE  in  1  access phase
- PWRITE  in  1  1 write, 0 read
- PADDR  in  32  byte address; only PADDR[3:2] decoded, others ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data; valid only while PREADY=1 in a read
- PREADY  out  1  transfer completion

## Operation
- Register map, selected by PADDR[3:2]:
  - 0x0 SCRATCH: read/write, 32 bits
  - 0x4 STATUS: read returns {count[31:4] zero-extended, underflow[3], overflow[2], full[1], empty[0]}, with count at bits [4 +: clog2(DEPTH)+1]. Write: bits 2 and 3 are write-1-to-clear; other bits are ignored.
  - 0x8 PUSH: write pushes PWDATA. If the FIFO is full, the data is dropped, overflow is set and the FIFO is unchanged. Read returns 0.
  - 0xC POP: read returns the head entry and pops it. If the FIFO is empty, the read returns 0, sets underflow and leaves the pointers unchanged. Write is ignored.
- All side effects commit only on the completion edge, meaning the rising edge with PSEL=1, PENABLE=1 and PREADY=1. This covers register writes, push, pop and sticky-flag set/clear.
- FIFO:
  - Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - count ranges 0..DEPTH.
  - empty = (count==0); full = (count==DEPTH).
- Only one access completes per transfer, so push and pop never coincide.
- A W1C write to STATUS takes priority over a flag set in the same cycle. This cannot happen in practice and needs no special handling beyond the priority rule.

## Timing
- FSM states and transitions:
  - IDLE to WAIT on PSEL=1 and PENABLE=0 (setup phase); wcnt is loaded with 0.
  - In WAIT with PSEL=1 and PENABLE=1:
    - PREADY = (wcnt==WAIT_CYCLES), generated combinationally from state and wcnt.
    - If PREADY=0, wcnt increments.
    - If PREADY=1, the transfer completes and the FSM goes to IDLE.
  - In WAIT, if PSEL drops before completion: abort to IDLE with no side effect.
- Back-to-back transfers: the master returns to its IDLE for at least one cycle, so the next setup is seen from IDLE.
- Access-phase length is WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, PREADY is high in the first access cycle.
- Outside the completing cycle, PREADY=0 and PRDATA=0.
  - PRDATA is combinational from the selected source during the PREADY=1 read cycle.
  - For POP, PRDATA shows the pre-pop head.
- Reset (PRESET=0 at a rising edge), taking effect at the same edge:
  - state=IDLE, wcnt=0
  - SCRATCH=0
  - pointers=0, count=0
  - overflow=underflow=0
  - PREADY=0, PRDATA=0
  - FIFO storage contents need not be cleared.
- Reset asserted mid-transfer aborts the transfer with no commit. The next transfer must begin with a fresh setup phase.

## Test plan
- Reset: hold PRESET=0 for 2 cycles, then release -> PREADY=0, PRDATA=0. Reading STATUS returns 0x0000_0001 (empty).
- Scratch with WAIT_CYCLES=1: write 0xDEAD_BEEF to 0x0, then read 0x0 -> PREADY low for exactly 1 access cycle then high on the 2nd; read data is 0xDEAD_BEEF.
- Fill/overflow with DEPTH=8: push 1..9 to 0x8 -> after the 8th push STATUS = 0x0000_0082 (count 8, full). After the 9th, STATUS = 0x0000_0086 (overflow set). Write 0x4 to STATUS -> reads 0x0000_0082.
- Drain/underflow: pop 9 times from 0xC -> returns 1..8 in order, then 0. Final STATUS = 0x0000_0009 (empty, underflow).
- Wrap-around: push 5, pop 5, push 6, pop 6 -> data is in order and count is 0 at the end, exercising pointer wrap past DEPTH.
- Abort/reset mid-op: drop PSEL during the wait phase of a PUSH of 0x1234 -> count is unchanged. Assert PRESET during the wait phase of a POP -> FIFO is empty afterwards and PREADY=0.
